// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared types and constants for the two-port SDRAM arbiter:
//               FSM state encoding, requester port indices, default timeout
//               and the data word returned on a timed-out transaction.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_ACCEPT   = 3'd2,
    ST_COMPLETE = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  localparam int PORT_SPI = 0;  // SPI host bridge
  localparam int PORT_CPU = 1;  // fxcpu

  localparam int TIMEOUT_DEFAULT = 1024;

  localparam logic [15:0] ERR_RDATA = 16'hDEAD;

endpackage
`default_nettype wire

// File: rtl/sdram_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_rr2
// Description : Combinational two-way round-robin selector. When both ports
//               request, the port that was NOT granted last wins; a lone
//               requester always wins.
// Ports       : req   - per-port request
//               last  - index of the port granted most recently
//               grant - one-hot grant (zero when no request)
//               valid - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arb_rr2
  import sdram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       valid
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? (2'b01 << PORT_SPI) : (2'b01 << PORT_CPU);
    end
  end

  assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Arbitrates two requesters (SPI host bridge, fxcpu) onto a
//               single sdram_controller. One transaction in flight at a time,
//               round-robin on contention, per-transaction timeout.
// Ports       : clk, rst                     - clock, sync active-high reset
//               m_req/m_we/m_addr/m_wdata    - per-requester request side
//               m_ack/m_err/m_rdata          - per-requester response side
//               wr_addr/wr_data/wr_enable    - controller write command
//               rd_addr/rd_enable            - controller read command
//               rd_data/rd_ready/busy        - controller status/return
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int ADDR_W         = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             m_req,
  input  logic [1:0]             m_we,
  input  logic [1:0][ADDR_W-1:0] m_addr,
  input  logic [1:0][15:0]       m_wdata,
  output logic [1:0]             m_ack,
  output logic [1:0]             m_err,
  output logic [15:0]            m_rdata,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [15:0]            wr_data,
  output logic                   wr_enable,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic                   rd_enable,
  input  logic [15:0]            rd_data,
  input  logic                   rd_ready,
  input  logic                   busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e              state_q;
  logic                sel_q;      // granted port index
  logic                last_q;     // port granted by the previous transaction
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rd_hit_q;   // read data already captured in ACCEPT
  logic [1:0]          m_ack_q;
  logic [1:0]          m_err_q;
  logic [15:0]         m_rdata_q;
  logic                wr_enable_q;
  logic                rd_enable_q;

  logic [1:0]          w_grant;
  logic                w_valid;
  logic                w_sel;
  logic                w_timeout;

  sdram_arb_rr2 u_rr2 (
    .req   (m_req),
    .last  (last_q),
    .grant (w_grant),
    .valid (w_valid)
  );

  assign w_sel     = w_grant[PORT_CPU] & ~w_grant[PORT_SPI];
  assign w_timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;         // port 0 wins the first tie
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rd_hit_q    <= 1'b0;
      m_ack_q     <= '0;
      m_err_q     <= '0;
      m_rdata_q   <= '0;
      wr_enable_q <= 1'b0;
      rd_enable_q <= 1'b0;
    end else begin
      // Pulsed outputs default low; they are raised only on the edge
      // entering ISSUE (enables) or RESP (ack/err).
      m_ack_q     <= '0;
      m_err_q     <= '0;
      wr_enable_q <= 1'b0;
      rd_enable_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (!busy && w_valid) begin
            sel_q       <= w_sel;
            we_q        <= m_we[w_sel];
            addr_q      <= m_addr[w_sel];
            wdata_q     <= m_wdata[w_sel];
            wr_enable_q <= m_we[w_sel];
            rd_enable_q <= ~m_we[w_sel];
            cnt_q       <= '0;
            rd_hit_q    <= 1'b0;
            state_q     <= ST_ISSUE;
          end
        end

        ST_ISSUE, ST_ACCEPT, ST_COMPLETE: begin
          if (w_timeout) begin
            m_ack_q[sel_q] <= 1'b1;
            m_err_q[sel_q] <= 1'b1;
            m_rdata_q      <= ERR_RDATA;
            state_q        <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            case (state_q)
              ST_ISSUE: state_q <= ST_ACCEPT;
              ST_ACCEPT: begin
                if (busy || (!we_q && rd_ready)) begin
                  // A controller that answers a read without ever showing
                  // busy would otherwise have its single rd_ready lost.
                  if (!we_q && rd_ready) begin
                    m_rdata_q <= rd_data;
                    rd_hit_q  <= 1'b1;
                  end
                  state_q <= ST_COMPLETE;
                end
              end
              ST_COMPLETE: begin
                if (we_q ? !busy : (rd_hit_q || rd_ready)) begin
                  if (!we_q && !rd_hit_q) begin
                    m_rdata_q <= rd_data;
                  end
                  m_ack_q[sel_q] <= 1'b1;
                  state_q        <= ST_RESP;
                end
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end

        ST_RESP: begin
          last_q  <= sel_q;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_ack     = m_ack_q;
  assign m_err     = m_err_q;
  assign m_rdata   = m_rdata_q;
  assign wr_addr   = addr_q;
  assign rd_addr   = addr_q;
  assign wr_data   = wdata_q;
  assign wr_enable = wr_enable_q;
  assign rd_enable = rd_enable_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Self-checking bench for sdram_arbiter with a behavioural
//               controller model and a round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

  localparam int AW = 32;
  localparam int TO = 16;

  logic                clk, rst;
  logic [1:0]          m_req, m_we, m_ack, m_err;
  logic [1:0][AW-1:0]  m_addr;
  logic [1:0][15:0]    m_wdata;
  logic [15:0]         m_rdata, wr_data, rd_data;
  logic [AW-1:0]       wr_addr, rd_addr;
  logic                wr_enable, rd_enable, rd_ready, busy, busy_m, force_busy;

  assign busy = busy_m | force_busy;

  sdram_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_addr(rd_addr), .rd_enable(rd_enable),
    .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int exp_last;     // reference model: port served most recently

  // ---------------- controller model ----------------
  int            ctl_lat  = 3;   // cycles busy stays high after a command
  bit            ctl_dead = 1'b0;
  int            ctl_cnt  = 0;
  bit            ctl_rd;
  logic [AW-1:0] ctl_addr;

  // Address 0x40000000 reads back 0x1234.
  function automatic logic [15:0] ctl_rdata(input logic [AW-1:0] a);
    return a[15:0] ^ a[31:16] ^ 16'h5234;
  endfunction

  initial begin
    busy_m = 1'b0; rd_ready = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      rd_ready = 1'b0;
      if (rst) begin
        busy_m = 1'b0; ctl_cnt = 0;
      end else if (ctl_cnt > 0) begin
        ctl_cnt--;
        if (ctl_cnt == 0) begin
          busy_m = 1'b0;
          if (ctl_rd) begin
            rd_ready = 1'b1;
            rd_data  = ctl_rdata(ctl_addr);
          end
        end
      end else if (!ctl_dead && (wr_enable || rd_enable)) begin
        busy_m   = 1'b1;
        ctl_cnt  = ctl_lat;
        ctl_rd   = rd_enable;
        ctl_addr = rd_addr;
      end
    end
  end

  // ---------------- monitor ----------------
  int            cyc = 0, n_wr = 0, n_rd = 0, n_ack_total = 0;
  int            n_double_en = 0, n_bad = 0, mon_en_cyc = 0, mon_ack_cyc = 0;
  bit            prev_en = 1'b0;
  logic [AW-1:0] mon_wr_addr, mon_rd_addr;
  logic [15:0]   mon_wr_data, mon_rdata;
  logic [1:0]    mon_ack, mon_err;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (wr_enable) begin n_wr++; mon_wr_addr = wr_addr; mon_wr_data = wr_data; mon_en_cyc = cyc; end
      if (rd_enable) begin n_rd++; mon_rd_addr = rd_addr; mon_en_cyc = cyc; end
      if ((wr_enable || rd_enable) && prev_en) n_double_en++;
      prev_en = wr_enable || rd_enable;
      if (m_ack == 2'b11 || (m_err & ~m_ack) != 2'b00) n_bad++;
      if (m_ack != 2'b00) begin
        n_ack_total++; mon_ack = m_ack; mon_err = m_err; mon_rdata = m_rdata; mon_ack_cyc = cyc;
      end
    end
  end

  task automatic wait_ack(input int budget, output bit got);
    int base;
    base = n_ack_total;
    got  = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk); #2;
      if (n_ack_total != base) got = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; m_req = '0;
    @(posedge clk); #1;
    checks++; if (m_ack !== 2'b00)   begin errors++; $display("FAIL reset_ack: got %b expected 00", m_ack); end
    checks++; if (m_err !== 2'b00)   begin errors++; $display("FAIL reset_err: got %b expected 00", m_err); end
    checks++; if (m_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", m_rdata); end
    checks++; if ({wr_enable, rd_enable} !== 2'b00) begin errors++; $display("FAIL reset_en: got %b expected 00", {wr_enable, rd_enable}); end
    checks++; if (wr_addr !== '0 || rd_addr !== '0 || wr_data !== '0) begin
      errors++; $display("FAIL reset_addr: got %h/%h/%h expected 0/0/0", wr_addr, rd_addr, wr_data); end
    @(negedge clk); rst = 1'b0;
    exp_last = 1;
  endtask

  task automatic test_write();
    int nwr, nrd, nack, t0; bit got;
    @(negedge clk);
    ctl_lat = 6; nwr = n_wr; nrd = n_rd; nack = n_ack_total;
    m_we[0] = 1'b1; m_addr[0] = '0; m_wdata[0] = 16'h5555; m_req = 2'b01; t0 = cyc;
    wait_ack(40, got);
    checks++; if (!got) begin errors++; $display("FAIL wr_ack_seen: got none expected ack"); end
    checks++; if (n_wr - nwr != 1 || n_rd != nrd) begin errors++; $display("FAIL wr_pulses: got wr=%0d rd=%0d expected 1/0", n_wr - nwr, n_rd - nrd); end
    checks++; if (mon_wr_addr !== 32'h0) begin errors++; $display("FAIL wr_addr: got %h expected 0", mon_wr_addr); end
    checks++; if (mon_wr_data !== 16'h5555) begin errors++; $display("FAIL wr_data: got %h expected 5555", mon_wr_data); end
    checks++; if (mon_ack !== 2'b01 || mon_err !== 2'b00) begin errors++; $display("FAIL wr_ack: got ack=%b err=%b expected 01/00", mon_ack, mon_err); end
    checks++; if (mon_ack_cyc - t0 < 4) begin errors++; $display("FAIL wr_latency: got %0d expected >=4", mon_ack_cyc - t0); end
    @(negedge clk); m_req = '0; exp_last = 0;
    repeat (3) @(negedge clk);
    checks++; if (n_ack_total - nack != 1) begin errors++; $display("FAIL wr_ack_once: got %0d expected 1", n_ack_total - nack); end
  endtask

  // Request is withdrawn right after the command is issued; the ack must still come.
  task automatic test_read();
    int nwr, nrd; bit got;
    @(negedge clk);
    ctl_lat = 3; nwr = n_wr; nrd = n_rd;
    m_we[1] = 1'b0; m_addr[1] = 32'h4000_0000; m_req = 2'b10;
    for (int i = 0; i < 10 && n_rd == nrd; i++) begin @(posedge clk); #2; end
    @(negedge clk); m_req = '0;
    wait_ack(30, got);
    checks++; if (!got) begin errors++; $display("FAIL rd_ack_seen: got none expected ack"); end
    checks++; if (n_rd - nrd != 1 || n_wr != nwr) begin errors++; $display("FAIL rd_pulses: got rd=%0d wr=%0d expected 1/0", n_rd - nrd, n_wr - nwr); end
    checks++; if (mon_rd_addr !== 32'h4000_0000) begin errors++; $display("FAIL rd_addr: got %h expected 40000000", mon_rd_addr); end
    checks++; if (mon_ack !== 2'b10 || mon_err !== 2'b00) begin errors++; $display("FAIL rd_ack: got ack=%b err=%b expected 10/00", mon_ack, mon_err); end
    checks++; if (mon_rdata !== 16'h1234) begin errors++; $display("FAIL rd_data: got %h expected 1234", mon_rdata); end
    exp_last = 1;
  endtask

  task automatic test_busy_hold();
    int nen, nack; bit got;
    @(negedge clk);
    force_busy = 1'b1; ctl_lat = 2; nen = n_wr + n_rd; nack = n_ack_total;
    m_we[1] = 1'b1; m_addr[1] = 32'h0000_0abc; m_wdata[1] = 16'hbeef; m_req = 2'b10;
    repeat (6) @(negedge clk);
    checks++; if (n_wr + n_rd != nen || n_ack_total != nack) begin errors++; $display("FAIL busy_hold: got en=%0d ack=%0d expected 0/0", n_wr + n_rd - nen, n_ack_total - nack); end
    force_busy = 1'b0;
    @(posedge clk); #1;
    checks++; if (wr_enable !== 1'b1) begin errors++; $display("FAIL busy_release_grant: got %b expected 1", wr_enable); end
    wait_ack(30, got);
    checks++; if (!got || mon_ack !== 2'b10) begin errors++; $display("FAIL busy_ack: got %b expected 10", mon_ack); end
    @(negedge clk); m_req = '0; exp_last = 1;
  endtask

  // both=1: both ports keep requesting n_txn each; both=0: random request mix.
  task automatic test_round_robin(input int n_txn, input bit both);
    int served[2]; int done, total, exp, nwr, nrd, pick; bit got;
    logic pwe[2]; logic [AW-1:0] pa[2]; logic [15:0] pd[2]; logic [1:0] exp_ack;
    served[0] = 0; served[1] = 0; done = 0; total = both ? 2 * n_txn : n_txn;
    @(negedge clk);
    while (done < total) begin
      pick = (!both && m_req == 2'b00) ? int'($urandom_range(0, 1)) : -1;
      for (int p = 0; p < 2; p++) begin
        if (!m_req[p] && (both ? served[p] < n_txn : (p == pick || $urandom_range(0, 1) == 1))) begin
          pwe[p] = 1'($urandom_range(0, 1)); pa[p] = $urandom; pd[p] = 16'($urandom);
          m_we[p] = pwe[p]; m_addr[p] = pa[p]; m_wdata[p] = pd[p]; m_req[p] = 1'b1;
        end
      end
      exp     = (m_req == 2'b11) ? 1 - exp_last : (m_req[1] ? 1 : 0);
      exp_ack = 2'(1 << exp);
      ctl_lat = $urandom_range(2, 8); nwr = n_wr; nrd = n_rd;
      wait_ack(60, got);
      checks++;
      if (!got) begin errors++; $display("FAIL rr_ack_seen: got none expected port %0d", exp); m_req = '0; return; end
      checks++; if (mon_ack !== exp_ack || mon_err !== 2'b00) begin errors++; $display("FAIL rr_grant: got ack=%b err=%b expected %b/00", mon_ack, mon_err, exp_ack); end
      if (pwe[exp]) begin
        checks++; if (n_wr - nwr != 1 || n_rd != nrd) begin errors++; $display("FAIL rr_wr_pulse: got wr=%0d rd=%0d expected 1/0", n_wr - nwr, n_rd - nrd); end
        checks++; if (mon_wr_addr !== pa[exp] || mon_wr_data !== pd[exp]) begin errors++; $display("FAIL rr_wr_cmd: got %h/%h expected %h/%h", mon_wr_addr, mon_wr_data, pa[exp], pd[exp]); end
      end else begin
        checks++; if (n_rd - nrd != 1 || n_wr != nwr) begin errors++; $display("FAIL rr_rd_pulse: got rd=%0d wr=%0d expected 1/0", n_rd - nrd, n_wr - nwr); end
        checks++; if (mon_rd_addr !== pa[exp] || mon_rdata !== ctl_rdata(pa[exp])) begin errors++; $display("FAIL rr_rd_cmd: got %h/%h expected %h/%h", mon_rd_addr, mon_rdata, pa[exp], ctl_rdata(pa[exp])); end
      end
      exp_last = exp; served[exp]++; done++;
      @(negedge clk); m_req[exp] = 1'b0;
    end
    m_req = '0;
  endtask

  task automatic test_timeout();
    int nrd; bit got;
    @(negedge clk);
    ctl_dead = 1'b1; nrd = n_rd;
    m_we[0] = 1'b0; m_addr[0] = $urandom; m_req = 2'b01;
    wait_ack(40, got);
    checks++; if (!got) begin errors++; $display("FAIL to_ack_seen: got none expected ack"); end
    checks++; if (mon_ack !== 2'b01 || mon_err !== 2'b01) begin errors++; $display("FAIL to_ack_err: got ack=%b err=%b expected 01/01", mon_ack, mon_err); end
    checks++; if (mon_rdata !== 16'hDEAD) begin errors++; $display("FAIL to_rdata: got %h expected dead", mon_rdata); end
    checks++; if (mon_ack_cyc - mon_en_cyc != TO) begin errors++; $display("FAIL to_cycles: got %0d expected %0d", mon_ack_cyc - mon_en_cyc, TO); end
    checks++; if (n_rd - nrd != 1) begin errors++; $display("FAIL to_pulses: got %0d expected 1", n_rd - nrd); end
    @(negedge clk); m_req = '0; ctl_dead = 1'b0; exp_last = 0;
    // A normal transaction right after shows the arbiter is back in idle.
    @(negedge clk);
    ctl_lat = 2; m_we[1] = 1'b1; m_addr[1] = 32'h10; m_wdata[1] = 16'h0f0f; m_req = 2'b10;
    wait_ack(30, got);
    checks++; if (!got || mon_ack !== 2'b10 || mon_err !== 2'b00) begin errors++; $display("FAIL to_recover: got ack=%b err=%b expected 10/00", mon_ack, mon_err); end
    @(negedge clk); m_req = '0; exp_last = 1;
  endtask

  task automatic test_reset_mid();
    int nrd, nack; bit got;
    @(negedge clk);
    ctl_lat = 8; nrd = n_rd;
    m_we = 2'b00; m_addr[1] = 32'h0000_7777; m_req = 2'b10;
    for (int i = 0; i < 10 && n_rd == nrd; i++) begin @(posedge clk); #2; end
    repeat (2) @(posedge clk);   // now in COMPLETE waiting on rd_ready
    @(negedge clk); rst = 1'b1; nack = n_ack_total;
    @(posedge clk); #1;
    checks++; if (m_ack !== 2'b00 || m_err !== 2'b00 || m_rdata !== 16'h0) begin errors++; $display("FAIL rmid_resp: got %b/%b/%h expected 00/00/0000", m_ack, m_err, m_rdata); end
    checks++; if ({wr_enable, rd_enable} !== 2'b00 || rd_addr !== '0 || wr_data !== '0) begin errors++; $display("FAIL rmid_cmd: got en=%b addr=%h data=%h expected 00/0/0", {wr_enable, rd_enable}, rd_addr, wr_data); end
    @(negedge clk); rst = 1'b0; m_req = '0; exp_last = 1;
    repeat (12) @(negedge clk);
    checks++; if (n_ack_total != nack) begin errors++; $display("FAIL rmid_no_ack: got %0d expected 0", n_ack_total - nack); end
    ctl_lat = 2; m_we = 2'b00; m_addr[0] = 32'h0000_0100; m_addr[1] = 32'h0000_0200; m_req = 2'b11;
    wait_ack(30, got);
    checks++; if (!got || mon_ack !== 2'b01) begin errors++; $display("FAIL rmid_first_grant: got %b expected 01", mon_ack); end
    @(negedge clk); m_req[0] = 1'b0;
    wait_ack(30, got);
    checks++; if (!got || mon_ack !== 2'b10) begin errors++; $display("FAIL rmid_second_grant: got %b expected 10", mon_ack); end
    @(negedge clk); m_req = '0;
  endtask

  initial begin
    rst = 1'b1; force_busy = 1'b0;
    m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_busy_hold();
    test_round_robin(4, 1'b1);
    test_round_robin(12, 1'b0);
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++; if (n_double_en != 0) begin errors++; $display("FAIL enable_width: got %0d long pulses expected 0", n_double_en); end
    checks++; if (n_bad != 0) begin errors++; $display("FAIL ack_err_onehot: got %0d bad cycles expected 0", n_bad); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: max cycles a granted transaction may wait for completion.
REQ-002 SHALL have parameter ADDR_W, default 32: requester and controller address width.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port m_req, input, 2: per-requester request; port 0 = SPI host bridge, port 1 = fxcpu; held until ack.
REQ-006 SHALL have port m_we, input, 2: per-requester 1=write, 0=read; stable while req is high.
REQ-007 SHALL have port m_addr, input, 2 x ADDR_W: per-requester address.
REQ-008 SHALL have port m_wdata, input, 2 x 16: per-requester write data.
REQ-009 SHALL have port m_ack, output, 2: one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port m_err, output, 2: one-cycle pulse coincident with m_ack when the transaction timed out.
REQ-011 SHALL have port m_rdata, output, 16: read data, valid in the m_ack cycle of a read.
REQ-012 SHALL have ports wr_addr/rd_addr (ADDR_W), wr_data (16), wr_enable, rd_enable outputs, and rd_data (16), rd_ready, busy inputs, matching sdram_controller.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, ACCEPT, COMPLETE, RESP.
REQ-014 IDLE: when busy=0 and any m_req high, SHALL grant one port, latch its we/addr/wdata, go to ISSUE next cycle; otherwise stay.
REQ-015 Both requesting: SHALL grant the port not granted last (round-robin); a lone requester SHALL be granted regardless of history.
REQ-016 ISSUE: SHALL drive wr_enable (write) or rd_enable (read) high for exactly one cycle with latched addr/data; go to ACCEPT.
REQ-017 ACCEPT: SHALL wait for busy=1 (or rd_ready=1 on a read), then go to COMPLETE.
REQ-018 COMPLETE, write: SHALL go to RESP on first cycle with busy=0.
REQ-019 COMPLETE, read: SHALL capture rd_data into m_rdata on first cycle with rd_ready=1 and go to RESP.
REQ-020 RESP: SHALL pulse m_ack[granted] for one cycle, update last-grant, return to IDLE; earliest next grant is the cycle after RESP.
REQ-021 A counter SHALL run from ISSUE to RESP; reaching TIMEOUT_CYCLES-1 SHALL force RESP with m_err pulsed and m_rdata=16'hDEAD.
REQ-022 Minimum latency, req sampled in IDLE to m_ack: 4 cycles plus controller busy/rd_ready time.
REQ-023 wr_addr/wr_data/rd_addr SHALL hold latched values outside ISSUE; enables SHALL be 0 outside ISSUE.
REQ-024 m_req dropped before ack SHALL NOT abort an issued transaction; ack still pulses.
REQ-025 m_ack/m_err SHALL never be asserted for a port not granted.

Reset
REQ-026 rst high SHALL, at next edge: state=IDLE, m_ack=0, m_err=0, m_rdata=0, wr_enable=0, rd_enable=0, addresses/data=0, counter=0, last-grant=1 (port 0 wins first tie).
REQ-027 rst mid-transaction SHALL abandon it with no ack; requesters re-request after reset.

Structure
REQ-028 Package sdram_arb_pkg SHALL hold the state enum, port index constants (PORT_SPI=0, PORT_CPU=1), TIMEOUT default, and the 16'hDEAD error constant.
REQ-029 Round-robin selection SHALL be a sub-module sdram_arb_rr2 (inputs req[2], last; outputs grant one-hot, valid), combinational.

Verification
REQ-030 Port 0 write 0x5555 to addr 0, busy model 6 cycles -> one wr_enable pulse, wr_addr=0, wr_data=0x5555, m_ack[0] once, m_err=0.
REQ-031 Port 1 read addr 0x40000000, model returns 0x1234 via rd_ready -> rd_enable one pulse, m_ack[1] with m_rdata=0x1234.
REQ-032 Both ports continuously request 4 transactions each -> grants alternate 0,1,0,1..., no port acked twice in a row.
REQ-033 Controller never raises busy/rd_ready, TIMEOUT_CYCLES=16 -> m_ack and m_err pulse together after 16 cycles, m_rdata=0xDEAD, FSM back in IDLE.
REQ-034 rst asserted during COMPLETE of a read -> next cycle all outputs at reset values, no m_ack; next request granted to port 0.
REQ-035 busy held high when req arrives -> no enable pulse until busy=0, then grant within 1 cycle.
